// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared ALU.
// Round-robin grant, operands latched on accept, result and flags captured
// after EXEC_CYCLES settle cycles, response held until the owner takes it.
module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1    // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_negative,
    output logic             rsp_borrow,
    output logic             rsp_carry_out,
    output logic             rsp_overflow,

    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_borrow,
    input  logic             alu_carry_out,
    input  logic             alu_overflow,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value on the final settle cycle.
    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             prio;       // preferred requester on a tie
    logic             gnt_q;      // requester owning the operation in flight
    logic             pick;       // requester that would win this cycle
    logic             accept;     // an operation is taken this cycle
    logic             exec_done;  // last settle cycle, capture now
    logic             rsp_hs;     // owner consumes the response
    logic [3:0]       exec_cnt;
    logic [3:0]       sel_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Arbitration: a lone requester wins, otherwise the preferred one does.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, so no latch can be inferred.
        pick = prio;
        if (req0_valid && !req1_valid) begin
            pick = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            pick = 1'b1;
        end
    end

    assign accept    = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign exec_done = (state == EXEC) && (exec_cnt == EXEC_LAST);
    assign rsp_hs    = (state == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

    // Next-state and handshake outputs of the IDLE/EXEC/RESP controller.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req0_ready = accept && !pick;
                req1_ready = accept && pick;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !gnt_q;
                rsp1_valid = gnt_q;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted operation, remember its owner, rotate the pointer on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these datapath registers carry a reset because reset must force alu_* and rsp_* to zero; storage without such a need would not.
        if (!rst_n) begin
            sel_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            gnt_q <= 1'b0;
            prio  <= 1'b0;
        end else begin
            if (accept) begin
                sel_q <= pick ? req1_sel : req0_sel;
                a_q   <= pick ? req1_a   : req0_a;
                b_q   <= pick ? req1_b   : req0_b;
                gnt_q <= pick;
            end
            if (rsp_hs) begin
                prio <= ~gnt_q;
            end
        end
    end

    // Settle-cycle counter: cleared on accept, advanced through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt <= '0;
        end else if (accept || exec_done) begin
            exec_cnt <= '0;
        end else if (state == EXEC) begin
            exec_cnt <= exec_cnt + 4'd1;
        end
    end

    // Capture the ALU result and its flags, unmodified, on the last settle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result    <= '0;
            rsp_negative  <= 1'b0;
            rsp_borrow    <= 1'b0;
            rsp_carry_out <= 1'b0;
            rsp_overflow  <= 1'b0;
        end else if (exec_done) begin
            rsp_result    <= alu_result;
            rsp_negative  <= alu_negative;
            rsp_borrow    <= alu_borrow;
            rsp_carry_out <= alu_carry_out;
            rsp_overflow  <= alu_overflow;
        end
    end

    // The shared ALU always sees the latched operation.
    assign alu_sel = sel_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Parameter: EXEC_CYCLES, 1, ALU settle cycles before capture; legal range 1..15.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-007 reqN_ready  out  1  operation of requester N accepted this cycle.
REQ-008 reqN_sel  in  4  ALU operation code of requester N.
REQ-009 reqN_a, reqN_b  in  WIDTH  operands of requester N.
REQ-010 rspN_valid  out  1  response for requester N available.
REQ-011 rspN_ready  in  1  requester N consumes the response.
REQ-012 rsp_result  out  WIDTH  captured ALU result, shared by both responses.
REQ-013 rsp_negative, rsp_borrow, rsp_carry_out, rsp_overflow  out  1 each  captured ALU flags.
REQ-014 alu_sel  out  4  operation code driven to the shared ALU.
REQ-015 alu_a, alu_b  out  WIDTH  operands driven to the shared ALU.
REQ-016 alu_result  in  WIDTH  ALU result.
REQ-017 alu_negative, alu_borrow, alu_carry_out, alu_overflow  in  1 each  flags from the ALU flag mux.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP.
REQ-020 In IDLE with any reqN_valid high, the block SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, latch its sel/a/b, and move to EXEC.
REQ-021 Arbitration SHALL be round-robin: a priority pointer selects the preferred requester, and on a tie the preferred requester wins.
REQ-022 The priority pointer SHALL point to the non-granted requester after each completed response handshake.
REQ-023 reqN_ready SHALL be low in EXEC and RESP, and low for the non-granted requester.
REQ-024 alu_sel/alu_a/alu_b SHALL be driven from the latched registers in all states, and SHALL hold their last values in IDLE.
REQ-025 EXEC SHALL last exactly EXEC_CYCLES cycles, counted by a 4-bit counter.
REQ-026 On the last EXEC cycle, the block SHALL register alu_result and all four flags into the rsp_* outputs and move to RESP.
REQ-027 In RESP, rspN_valid SHALL be high only for the granted requester, and rsp_* SHALL be stable until that requester's rspN_ready is high.
REQ-028 On rspN_valid and rspN_ready both high, the block SHALL return to IDLE the following cycle; back-to-back acceptance is therefore one IDLE cycle.
REQ-029 Accept-to-rspN_valid latency SHALL be EXEC_CYCLES+1 cycles.
REQ-030 Flags SHALL be passed through unmodified; no recomputation is done for non-add/sub codes.
REQ-031 A requester dropping reqN_valid while not granted SHALL have no effect, and latched operands SHALL not change after acceptance.
REQ-032 rspN_ready asserted outside RESP, or for the non-granted requester, SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, pointer to requester 0, EXEC counter 0, all rsp_* 0, rspN_valid 0, latched sel/a/b 0 (hence alu_* 0), busy 0.
REQ-034 Reset asserted mid-EXEC or mid-RESP SHALL discard the operation without issuing any response.
REQ-035 reqN_ready SHALL be 0 while rst_n is low.

Verification
REQ-036 Single op: req0 sel=0000 a=0x7FFFFFFF b=1 (ALU model returns 0x80000000, N=1, OVF=1) -> req0_ready pulses 1 cycle, rsp0_valid after EXEC_CYCLES+1 with result 0x80000000, negative=1, overflow=1.
REQ-037 Contention: both valid in IDLE after reset -> req0 granted first; with both still valid after rsp0 handshake -> req1 granted next; grants alternate 0,1,0,1 over 4 ops.
REQ-038 Backpressure: rsp1_ready held low 5 cycles in RESP -> rsp1_valid and rsp_result held constant; released -> IDLE next cycle.
REQ-039 Subtract: sel=1000 a=3 b=5 (model: result 0xFFFFFFFE, borrow=1) -> rsp borrow=1, carry_out=0, no other grant during busy.
REQ-040 Reset mid-EXEC with EXEC_CYCLES=4, rst_n low at cycle 2 -> no rspN_valid ever for that op; all outputs 0; next req0 accepted normally.
REQ-041 Stale ready: rsp0_ready high while req1 response pending -> ignored; rsp1_valid stays high.
